// File: rtl/spi_reg_bank.sv
// SPI write/read register bank: NUM_REGS x DATA_W registers loaded from nCS/SCLK/COPI frames.
// Optional CIPO readback is built only when SPI_REG_READBACK_EN is defined.
module spi_reg_bank #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 5,
   parameter int SPI_MODE = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         nCS,
   input  logic                         SCLK,
   input  logic                         COPI,
   output logic                         CIPO,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic                         frame_err
);

   localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam bit CPOL      = ((SPI_MODE >> 1) & 1) != 0;
   localparam bit CPHA      = (SPI_MODE & 1) != 0;

   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_LEN - 1);

   logic [1:0]            ncs_sync_q, sclk_sync_q, copi_sync_q;
   logic                  ncs_s, sclk_s, copi_s;
   logic                  ncs_prev_q, sclk_prev_q;
   logic                  armed_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_LEN-2:0]  shift_q, shift_d;
   logic [DATA_W-1:0]     regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   strobe_q;
   logic                  frame_err_q;

   logic                  sclk_rise, sclk_fall, sample_edge;
   logic                  in_frame, sampling, final_bit, ncs_rise;
   logic [FRAME_LEN-1:0]  word_now;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  addr_ok, commit, abort;

   assign ncs_s  = ncs_sync_q[1];
   assign sclk_s = sclk_sync_q[1];
   assign copi_s = copi_sync_q[1];

   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;

   // Qualified on the previous nCS so a final edge landing with the nCS rise still counts.
   assign in_frame  = armed_q & ~ncs_prev_q;
   assign sampling  = in_frame & sample_edge & (cnt_q < LEN_C);
   assign final_bit = sampling & (cnt_q == LAST_C);
   assign ncs_rise  = ncs_s & ~ncs_prev_q;

   assign word_now = {shift_q, copi_s};
   assign wr_addr  = word_now[FRAME_LEN-2 -: ADDR_W];
   assign wr_data  = word_now[DATA_W-1:0];
   assign addr_ok  = {1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS);
   assign commit   = final_bit & word_now[FRAME_LEN-1] & addr_ok;
   assign abort    = ncs_rise & (cnt_q != '0) & (cnt_q < LEN_C) & ~final_bit;

   always_comb begin
      // NOTE: defaults first so every path assigns, otherwise a latch is inferred.
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (ncs_s || !armed_q) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (sampling) begin
         cnt_d   = cnt_q + CNT_W'(1);
         shift_d = word_now[FRAME_LEN-2:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // nCS sync resets low so a frame in flight is never mistaken for idle.
         ncs_sync_q  <= '0;
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_prev_q  <= 1'b0;
         sclk_prev_q <= 1'b0;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         strobe_q    <= '0;
         frame_err_q <= 1'b0;
         // NOTE: the register file is reset explicitly; its outputs drive live PWM/IO logic.
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         ncs_sync_q  <= {ncs_sync_q[0], nCS};
         sclk_sync_q <= {sclk_sync_q[0], SCLK};
         copi_sync_q <= {copi_sync_q[0], COPI};
         ncs_prev_q  <= ncs_s;
         sclk_prev_q <= sclk_s;
         if (ncs_s) armed_q <= 1'b1;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= abort;
         for (int r = 0; r < NUM_REGS; r++) begin
            strobe_q[r] <= commit && (wr_addr == ADDR_W'(r));
            if (commit && (wr_addr == ADDR_W'(r))) regs_q[r] <= wr_data;
         end
      end
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
      assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
   end

   assign wr_strobe = strobe_q;
   assign frame_err = frame_err_q;

`ifdef SPI_REG_READBACK_EN
   logic                  shift_edge, addr_done;
   logic [ADDR_W-1:0]     rd_addr;
   logic [DATA_W-1:0]     rd_val;
   logic [DATA_W-1:0]     out_sh_q;
   logic                  cipo_q, oe_q;

   assign shift_edge = (CPOL == CPHA) ? sclk_fall : sclk_rise;
   assign addr_done  = sampling & (cnt_q == CNT_W'(ADDR_W)) & ~word_now[ADDR_W];
   assign rd_addr    = word_now[ADDR_W-1:0];

   always_comb begin
      rd_val = '0;
      for (int r = 0; r < NUM_REGS; r++)
         if (rd_addr == ADDR_W'(r)) rd_val = regs_q[r];
   end

   // With CPHA=0 the MSB goes out at load; the shift edge that follows re-drives it,
   // so each later shift edge presents the next bit ahead of the master's sample edge.
   always_ff @(posedge clk) begin
      if (rst || ncs_s) begin
         out_sh_q <= '0;
         cipo_q   <= 1'b0;
         oe_q     <= 1'b0;
      end else if (addr_done) begin
         out_sh_q <= rd_val;
         oe_q     <= 1'b1;
         if (!CPHA) cipo_q <= rd_val[DATA_W-1];
      end else if (shift_edge) begin
         cipo_q   <= out_sh_q[DATA_W-1];
         out_sh_q <= {out_sh_q[DATA_W-2:0], 1'b0};
      end
   end

   assign CIPO    = cipo_q;
   assign cipo_oe = oe_q;
`else
   assign CIPO    = 1'b0;
   assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: one instance per SPI mode, bit-banged frames checked
// against an array model of the register map (readback checks follow SPI_REG_READBACK_EN).
module tb_spi_reg_bank;

   localparam int CLK_P = 10;
   localparam int HP    = 80;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ncs;
   logic [3:0]  sclk;
   logic        copi;
   wire  [3:0]  cipo;
   wire  [3:0]  oe;
   wire  [39:0] regs_flat [4];
   wire  [4:0]  wr_strobe [4];
   wire  [3:0]  frame_err;

   int n_checks = 0;
   int n_errors = 0;

   int         strobe_cycles [4] = '{default: 0};
   int         err_pulses    [4] = '{default: 0};
   logic [4:0] strobe_last   [4] = '{default: '0};
   logic [7:0] model [4][5];

   always #(CLK_P/2) clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      spi_reg_bank #(.SPI_MODE(m)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .nCS       (ncs[m]),
         .SCLK      (sclk[m]),
         .COPI      (copi),
         .CIPO      (cipo[m]),
         .cipo_oe   (oe[m]),
         .regs_flat (regs_flat[m]),
         .wr_strobe (wr_strobe[m]),
         .frame_err (frame_err[m])
      );
   end

   always @(negedge clk) begin
      for (int m = 0; m < 4; m++) begin
         if (wr_strobe[m] != '0) begin
            strobe_cycles[m]++;
            strobe_last[m] = wr_strobe[m];
         end
         if (frame_err[m]) err_pulses[m]++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] model_flat(input int m);
      logic [39:0] f;
      for (int r = 0; r < 5; r++) f[r*8 +: 8] = model[m][r];
      return f;
   endfunction

   task automatic spi_frame(input int m, input logic [15:0] word, input int nbits,
                            input int rst_at, output logic [7:0] rd, output logic oe_end);
      logic cpol, cpha, b;
      cpol = m[1];
      cpha = m[0];
      rd   = '0;
      ncs[m] = 1'b0;
      #HP;
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
         end
         b = (i < 16) ? word[15-i] : 1'b1;
         if (!cpha) begin
            copi = b;
            #HP;
            if (i >= 8 && i < 16) rd = {rd[6:0], cipo[m]};
            sclk[m] = ~cpol;
            #HP;
            sclk[m] = cpol;
         end else begin
            sclk[m] = ~cpol;
            copi = b;
            #HP;
            if (i >= 8 && i < 16) rd = {rd[6:0], cipo[m]};
            sclk[m] = cpol;
            #HP;
         end
      end
      #HP;
      oe_end = oe[m];
      ncs[m] = 1'b1;
      #(8*CLK_P);
   endtask

   task automatic do_frame(input int m, input logic rw, input logic [6:0] addr,
                           input logic [7:0] data, input int nbits, input int rst_at,
                           input string tag);
      int         sc0, ec0, a;
      logic [7:0] rd, exp_rd;
      logic       oe_end, wr, ab, rst_hit, full;
      a      = int'(addr);
      sc0    = strobe_cycles[m];
      ec0    = err_pulses[m];
      exp_rd = (a < 5) ? model[m][a] : 8'h00;
      spi_frame(m, {rw, addr, data}, nbits, rst_at, rd, oe_end);
      rst_hit = (rst_at >= 0) && (rst_at < nbits);
      full    = nbits >= 16;
      if (rst_hit) begin
         for (int k = 0; k < 4; k++)
            for (int r = 0; r < 5; r++) model[k][r] = 8'h00;
         wr = 1'b0;
         ab = 1'b0;
      end else begin
         wr = full && rw && (a < 5);
         ab = !full;
      end
      if (wr) model[m][a] = data;
      check({tag, "_regs"}, regs_flat[m], model_flat(m));
      check({tag, "_strobe_cycles"}, strobe_cycles[m] - sc0, wr);
      if (wr) check({tag, "_strobe_bit"}, strobe_last[m], 64'(5'b1 << a));
      check({tag, "_frame_err"}, err_pulses[m] - ec0, ab);
      check({tag, "_idle_out"}, {oe[m], cipo[m]}, 2'b00);
      if (!rw && full && !rst_hit) begin
`ifdef SPI_REG_READBACK_EN
         check({tag, "_rd_data"}, rd, exp_rd);
         check({tag, "_rd_oe"}, oe_end, 1'b1);
`else
         check({tag, "_rd_data"}, rd, 8'h00);
         check({tag, "_rd_oe"}, oe_end, 1'b0);
`endif
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < 5; r++) model[k][r] = 8'h00;
      rst  = 1'b1;
      ncs  = 4'hF;
      sclk = 4'b1100;
      copi = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int m = 0; m < 4; m++) begin
         check($sformatf("reset_regs_m%0d", m), regs_flat[m], 40'h0);
         check($sformatf("reset_strobe_m%0d", m), wr_strobe[m], 5'h0);
         check($sformatf("reset_outs_m%0d", m), {frame_err[m], oe[m], cipo[m]}, 3'b000);
      end
      rst = 1'b0;
      #(10*CLK_P);

      do_frame(0, 1'b1, 7'h04, 8'hA5, 16, -1, "m0_wr_reg4");
      do_frame(0, 1'b1, 7'h7F, 8'hFF, 16, -1, "m0_wr_oob");
      do_frame(0, 1'b1, 7'h01, 8'h3C, 10, -1, "m0_abort10");
      do_frame(0, 1'b1, 7'h01, 8'h3C, 16, -1, "m0_wr_reg1");
      do_frame(0, 1'b1, 7'h02, 8'h5A, 16, -1, "m0_wr_reg2");
      do_frame(0, 1'b0, 7'h02, 8'h00, 16, -1, "m0_rd_reg2");
      do_frame(0, 1'b0, 7'h7F, 8'h00, 16, -1, "m0_rd_oob");
      do_frame(0, 1'b1, 7'h00, 8'h81, 20, -1, "m0_wr_extra");
      for (int m = 1; m < 4; m++) begin
         do_frame(m, 1'b1, 7'h02, 8'h5A, 16, -1, $sformatf("m%0d_wr_reg2", m));
         do_frame(m, 1'b0, 7'h02, 8'h00, 16, -1, $sformatf("m%0d_rd_reg2", m));
         do_frame(m, 1'b1, 7'h04, 8'hA5, 16, -1, $sformatf("m%0d_wr_reg4", m));
         do_frame(m, 1'b0, 7'h04, 8'h00, 16, -1, $sformatf("m%0d_rd_reg4", m));
      end
      do_frame(0, 1'b1, 7'h03, 8'h77, 16, 12, "m0_rst_mid");
      do_frame(0, 1'b1, 7'h03, 8'h77, 16, -1, "m0_after_rst");

      for (int m = 0; m < 4; m++) begin
         for (int n = 0; n < 20; n++) begin
            logic       rw;
            logic [6:0] addr;
            logic [7:0] data;
            int         kind, nbits;
            rw    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
            data  = 8'($urandom);
            kind  = int'($urandom_range(0, 9));
            nbits = (kind == 0) ? int'($urandom_range(1, 15)) :
                    (kind == 1) ? int'($urandom_range(17, 20)) : 16;
            do_frame(m, rw, addr, data, nbits, -1, $sformatf("rand_m%0d_%0d", m, n));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
